b_resp_rr_arbiter_n: RTL and testbench



---
 rtl/b_resp_rr_arbiter_n.sv | 137 +++++++++++++
 tb/tb_b_resp_rr_arbiter_n.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_resp_rr_arbiter_n.sv
// Write-response (B channel) arbiter: merges NUM_SLV slave B channels onto one
// registered master B channel, using round-robin or fixed-priority selection.
module b_resp_rr_arbiter_n #(
  parameter  int NUM_SLV = 5,
  parameter  int SID_W   = 6,
  parameter  int RESP_W  = 2,
  localparam int IDX_W   = $clog2(NUM_SLV)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      prio_mode,
  input  logic [NUM_SLV-1:0]        s_bvalid,
  input  logic [NUM_SLV*SID_W-1:0]  s_bid,
  input  logic [NUM_SLV*RESP_W-1:0] s_bresp,
  output logic [NUM_SLV-1:0]        s_bready,
  output logic                      m_bvalid,
  output logic [SID_W-1:0]          m_bid,
  output logic [RESP_W-1:0]         m_bresp,
  input  logic                      m_bready,
  output logic [IDX_W-1:0]          grant_idx
);

  // state | meaning
  // IDLE  | output stage empty
  // HOLD  | output stage carries a response waiting for m_bready
  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_SLV-1:0] cand;
  logic [IDX_W-1:0]   search_ptr;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [SID_W-1:0]   win_bid;
  logic [RESP_W-1:0]  win_bresp;

  // While holding, the served slave still shows BVALID and must be masked out;
  // the search also starts after it, matching the rr_ptr update on handshake.
  always_comb begin
    cand       = s_bvalid;
    search_ptr = rr_ptr;
    if (state == HOLD) begin
      search_ptr = grant_idx;
      for (int i = 0; i < NUM_SLV; i++) begin
        if (grant_idx == IDX_W'(i)) cand[i] = 1'b0;
      end
    end
  end

  always_comb begin
    int pos;
    pos       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    if (prio_mode) begin
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Walk offsets downward so the last hit is the nearest one above search_ptr.
      for (int k = NUM_SLV; k >= 1; k--) begin
        pos = int'(search_ptr) + k;
        if (pos >= NUM_SLV) pos = pos - NUM_SLV;
        for (int i = 0; i < NUM_SLV; i++) begin
          if (cand[i] && (i == pos)) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    win_bid   = '0;
    win_bresp = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_bid   = s_bid[i*SID_W +: SID_W];
        win_bresp = s_bresp[i*RESP_W +: RESP_W];
      end
    end
  end

  always_comb begin
    s_bready = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      s_bready[i] = m_bvalid & m_bready & (grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_SLV - 1);
      grant_idx <= IDX_W'(NUM_SLV - 1);
      m_bvalid  <= 1'b0;
      m_bid     <= '0;
      m_bresp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            m_bid     <= win_bid;
            m_bresp   <= win_bresp;
            m_bvalid  <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (m_bready) begin
            rr_ptr <= grant_idx;
            if (win_found) begin
              grant_idx <= win_idx;
              m_bid     <= win_bid;
              m_bresp   <= win_bresp;
            end else begin
              m_bvalid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A granted slave must keep BVALID high until its response is accepted.
  a_bvalid_held: assert property (@(posedge clk) disable iff (!reset_n)
    m_bvalid |-> s_bvalid[grant_idx])
    else $error("granted slave dropped BVALID before handshake");

endmodule

// File: tb/tb_b_resp_rr_arbiter_n.sv
// Self-checking bench for b_resp_rr_arbiter_n: queue-driven slaves, a
// transaction-level reference model, directed scenarios and random traffic.
module tb_b_resp_rr_arbiter_n;
  localparam int N  = 5;
  localparam int SW = 6;
  localparam int RW = 2;
  localparam int IW = 3;

  logic            clk;
  logic            reset_n;
  logic            prio_mode;
  logic [N-1:0]    s_bvalid;
  logic [N*SW-1:0] s_bid;
  logic [N*RW-1:0] s_bresp;
  logic [N-1:0]    s_bready;
  logic            m_bvalid;
  logic [SW-1:0]   m_bid;
  logic [RW-1:0]   m_bresp;
  logic            m_bready;
  logic [IW-1:0]   grant_idx;

  int n_tests;
  int n_fail;

  logic [SW+RW-1:0] q [N][$];
  int served[$];

  // reference model: current output stage and last-served pointer
  bit            mv_valid, nx_valid;
  int            mv_grant, nx_grant, mv_ptr, nx_ptr, hs_slave;
  logic [SW-1:0] mv_id, nx_id;
  logic [RW-1:0] mv_resp, nx_resp;

  b_resp_rr_arbiter_n dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .prio_mode (prio_mode),
    .s_bvalid  (s_bvalid),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .s_bready  (s_bready),
    .m_bvalid  (m_bvalid),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bready  (m_bready),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] c, input logic fixed, input int ptr);
    if (fixed) begin
      for (int i = 0; i < N; i++) if (c[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (c[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_sready();
    if (mv_valid && m_bready === 1'b1) return 32'(1) << mv_grant;
    return 32'd0;
  endfunction

  task automatic model_reset();
    mv_valid = 0; mv_grant = N - 1; mv_ptr = N - 1; mv_id = '0; mv_resp = '0;
    hs_slave = -1;
  endtask

  task automatic model_eval();
    logic [N-1:0] c;
    int w;
    bit hs;
    hs = mv_valid && m_bready;
    nx_valid = mv_valid; nx_grant = mv_grant; nx_ptr = mv_ptr;
    nx_id = mv_id; nx_resp = mv_resp; hs_slave = -1;
    if (hs) begin
      hs_slave = mv_grant;
      nx_ptr   = mv_grant;
    end
    if (!mv_valid || hs) begin
      c = s_bvalid;
      if (hs) c[mv_grant] = 1'b0;
      w = pick(c, prio_mode, nx_ptr);
      if (w >= 0) begin
        nx_valid = 1; nx_grant = w;
        nx_id    = s_bid[w*SW +: SW];
        nx_resp  = s_bresp[w*RW +: RW];
      end else begin
        nx_valid = 0;
      end
    end
  endtask

  task automatic push(input int i, input logic [SW-1:0] id, input logic [RW-1:0] r);
    q[i].push_back({id, r});
  endtask

  task automatic drive();
    logic [SW+RW-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        e = q[i][0];
        s_bvalid[i]          = 1'b1;
        s_bid[i*SW +: SW]    = e[SW+RW-1:RW];
        s_bresp[i*RW +: RW]  = e[RW-1:0];
      end else begin
        s_bvalid[i]          = 1'b0;
        s_bid[i*SW +: SW]    = '0;
        s_bresp[i*RW +: RW]  = '0;
      end
    end
  endtask

  // one clock: called and returns at posedge+1 with inputs settled
  task automatic cycle();
    if (m_bvalid && m_bready) served.push_back(int'(grant_idx));
    model_eval();
    @(posedge clk);
    #1;
    mv_valid = nx_valid; mv_grant = nx_grant; mv_ptr = nx_ptr;
    mv_id = nx_id; mv_resp = nx_resp;
    if (hs_slave >= 0 && q[hs_slave].size() > 0) q[hs_slave].delete(0);
    drive();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    m_bready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      done = 1;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) done = 0;
      if (m_bvalid) done = 0;
      if (!done) cycle();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_bvalid",  32'(m_bvalid),  32'(mv_valid));
      chk("m_bid",     32'(m_bid),     32'(mv_id));
      chk("m_bresp",   32'(m_bresp),   32'(mv_resp));
      chk("grant_idx", 32'(grant_idx), 32'(mv_grant));
      chk("s_bready",  32'(s_bready),  exp_sready());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    int exp_rr[6];
    int exp_fp[3];
    exp_rr = '{0, 1, 2, 3, 4, 0};
    exp_fp = '{0, 4, 0};
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; prio_mode = 1'b0; m_bready = 1'b0;
    s_bvalid = '0; s_bid = '0; s_bresp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_bvalid",  32'(m_bvalid),  32'd0);
    chk("rst_m_bid",     32'(m_bid),     32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd4);
    chk("rst_s_bready",  32'(s_bready),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single request
    push(2, 6'h15, 2'b10);
    m_bready = 1'b1;
    drive();
    cycle();
    chk("t1_m_bvalid",  32'(m_bvalid),  32'd1);
    chk("t1_m_bid",     32'(m_bid),     32'h15);
    chk("t1_m_bresp",   32'(m_bresp),   32'd2);
    chk("t1_grant_idx", 32'(grant_idx), 32'd2);
    chk("t1_s_bready",  32'(s_bready),  32'b00100);
    cycle();
    chk("t1_m_bvalid_drop", 32'(m_bvalid), 32'd0);
    drain();

    // all five requesting, round-robin
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, SW'($urandom), RW'($urandom));
      push(i, SW'($urandom), RW'($urandom));
    end
    m_bready = 1'b1;
    served.delete();
    drive();
    bubbles = 0;
    repeat (7) begin
      cycle();
      if (served.size() < 6 && !m_bvalid) bubbles++;
    end
    chk("t2_count", 32'(served.size()), 32'd6);
    for (int i = 0; i < 6 && i < served.size(); i++) chk("t2_rr_seq", 32'(served[i]), 32'(exp_rr[i]));
    chk("t2_bubbles", 32'(bubbles), 32'd0);
    drain();

    // backpressure
    do_reset();
    push(1, 6'h2A, 2'b01);
    push(3, 6'h33, 2'b11);
    m_bready = 1'b0;
    drive();
    cycle();
    chk("t3_grant_first", 32'(grant_idx), 32'd1);
    repeat (4) begin
      cycle();
      chk("t3_grant_hold", 32'(grant_idx), 32'd1);
      chk("t3_bid_hold",   32'(m_bid),     32'h2A);
      chk("t3_bresp_hold", 32'(m_bresp),   32'd1);
      chk("t3_sready_off", 32'(s_bready),  32'd0);
    end
    m_bready = 1'b1;
    #1;
    chk("t3_sready_hs", 32'(s_bready), 32'b00010);
    cycle();
    chk("t3_grant_next", 32'(grant_idx), 32'd3);
    chk("t3_bid_next",   32'(m_bid),     32'h33);
    drain();

    // fixed priority, slave 0 re-presenting
    do_reset();
    prio_mode = 1'b1;
    push(0, 6'h10, 2'b00);
    push(0, 6'h11, 2'b00);
    push(4, 6'h24, 2'b01);
    m_bready = 1'b1;
    served.delete();
    drive();
    repeat (4) cycle();
    chk("t4_count", 32'(served.size()), 32'd3);
    for (int i = 0; i < 3 && i < served.size(); i++) chk("t4_fp_seq", 32'(served[i]), 32'(exp_fp[i]));
    drain();
    prio_mode = 1'b0;

    // back-to-back from one slave
    do_reset();
    push(3, 6'h01, 2'b00);
    push(3, 6'h02, 2'b00);
    m_bready = 1'b1;
    drive();
    cycle();
    chk("t5_v0",   32'(m_bvalid), 32'd1);
    chk("t5_bid0", 32'(m_bid),    32'h01);
    cycle();
    chk("t5_v1",   32'(m_bvalid), 32'd0);
    cycle();
    chk("t5_v2",   32'(m_bvalid), 32'd1);
    chk("t5_bid2", 32'(m_bid),    32'h02);
    drain();

    // reset while holding
    do_reset();
    push(1, 6'h3C, 2'b10);
    m_bready = 1'b0;
    drive();
    cycle();
    chk("t6_holding", 32'(m_bvalid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_m_bvalid",  32'(m_bvalid),  32'd0);
    chk("t6_rst_m_bid",     32'(m_bid),     32'd0);
    chk("t6_rst_m_bresp",   32'(m_bresp),   32'd0);
    chk("t6_rst_grant_idx", 32'(grant_idx), 32'd4);
    model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 6'h05, 2'b00);
    push(2, 6'h06, 2'b01);
    prio_mode = 1'b0;
    m_bready  = 1'b0;
    drive();
    cycle();
    chk("t6_first_grant", 32'(grant_idx), 32'd0);
    drain();

    // random traffic
    do_reset();
    repeat (3000) begin
      m_bready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) prio_mode = ~prio_mode;
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) push(i, SW'($urandom), RW'($urandom));
      end
      drive();
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
